// File: rtl/abs_diff_pkg.sv
// Shared types and arithmetic helper for the sum-of-absolute-differences engine.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package abs_diff_pkg;

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CMP_EQ = 2'd0,
      CMP_GT = 2'd1,
      CMP_LT = 2'd2
   } cmp_t;

   // Adds at full precision, then clamps to the w-bit all-ones value
   // (saturate=1) or keeps the low w bits (saturate=0). w must be <= 31.
   function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                           input logic [31:0] inc,
                                           input int unsigned w,
                                           input bit          saturate);
      logic [32:0] full;
      logic [32:0] lim;
      full = {1'b0, acc} + {1'b0, inc};
      lim  = (33'd1 << w) - 33'd1;
      if (saturate && (full > lim)) begin
         return lim[31:0];
      end
      return full[31:0] & lim[31:0];
   endfunction

endpackage

// File: rtl/abs_diff_lane.sv
// One lane: unsigned compare of a against b plus registered absolute difference.
// Latency: 1 cycle from load to diff/cmp.
// Backpressure: none; holds its last result while load is low.
module abs_diff_lane
   import abs_diff_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             load,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output cmp_t             cmp
);

   // Capture |a-b| and the compare outcome for an accepted beat.
   always_ff @(posedge clk) begin
      if (RESET) begin
         diff <= '0;
         cmp  <= CMP_EQ;
      end else if (load) begin
         if (a > b) begin
            diff <= a - b;
            cmp  <= CMP_GT;
         end else if (a < b) begin
            diff <= b - a;
            cmp  <= CMP_LT;
         end else begin
            diff <= '0;
            cmp  <= CMP_EQ;
         end
      end
   end

endmodule

// File: rtl/abs_diff_accum.sv
// Per-packet sum of absolute differences and GT/LT/EQ lane counts over CHANNELS lanes.
// Latency: last beat accepted in cycle T -> result valid in cycle T+2.
// Backpressure: in_ready drops from the last beat until the result is taken; result held until out_ready.
module abs_diff_accum
   import abs_diff_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int ACC_W    = 16,
   parameter int CNT_W    = 8,
   parameter int SATURATE = 1
) (
   input  logic                      clk,
   input  logic                      RESET,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_a,
   input  logic [CHANNELS*WIDTH-1:0] in_b,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_W-1:0]          out_sum,
   output logic [CNT_W-1:0]          out_gt_cnt,
   output logic [CNT_W-1:0]          out_lt_cnt,
   output logic [CNT_W-1:0]          out_eq_cnt,
   output logic                      out_sat
);

   localparam logic [31:0] SUM_MAX = (32'd1 << ACC_W) - 32'd1;
   localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             s1_vld;
   logic             s1_last;
   logic [WIDTH-1:0] lane_diff [CHANNELS];
   cmp_t             lane_cmp  [CHANNELS];
   logic [31:0]      beat_sum;
   logic [31:0]      beat_gt;
   logic [31:0]      beat_lt;
   logic [31:0]      beat_eq;
   logic [31:0]      sum_full;
   logic [31:0]      gt_full;
   logic [31:0]      lt_full;
   logic [31:0]      eq_full;
   logic             sat_hit;

   assign accept = in_valid && in_ready;

   // Stage 1: one registered compare/abs-diff unit per lane.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      abs_diff_lane #(.WIDTH(WIDTH)) u_lane (
         .clk   (clk),
         .RESET (RESET),
         .load  (accept),
         .a     (in_a[g*WIDTH +: WIDTH]),
         .b     (in_b[g*WIDTH +: WIDTH]),
         .diff  (lane_diff[g]),
         .cmp   (lane_cmp[g])
      );
   end

   // Stage-1 valid and end-of-packet marker travel alongside the lane registers.
   always_ff @(posedge clk) begin
      if (RESET) begin
         s1_vld  <= 1'b0;
         s1_last <= 1'b0;
      end else begin
         s1_vld  <= accept;
         s1_last <= accept && in_last;
      end
   end

   // Stage 2 combine: reduce lane diffs and popcount the compare outcomes.
   always_comb begin
      beat_sum = '0;
      beat_gt  = '0;
      beat_lt  = '0;
      beat_eq  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         beat_sum = beat_sum + 32'(lane_diff[i]);
         if (lane_cmp[i] == CMP_GT) beat_gt = beat_gt + 32'd1;
         if (lane_cmp[i] == CMP_LT) beat_lt = beat_lt + 32'd1;
         if (lane_cmp[i] == CMP_EQ) beat_eq = beat_eq + 32'd1;
      end
   end

   // Next accumulator values (clamped or wrapped) and the all-ones detector.
   always_comb begin
      sum_full = sat_add(32'(out_sum),    beat_sum, unsigned'(ACC_W), SATURATE != 0);
      gt_full  = sat_add(32'(out_gt_cnt), beat_gt,  unsigned'(CNT_W), SATURATE != 0);
      lt_full  = sat_add(32'(out_lt_cnt), beat_lt,  unsigned'(CNT_W), SATURATE != 0);
      eq_full  = sat_add(32'(out_eq_cnt), beat_eq,  unsigned'(CNT_W), SATURATE != 0);
      sat_hit  = (SATURATE != 0) &&
                 ((sum_full == SUM_MAX) || (gt_full == CNT_MAX) ||
                  (lt_full == CNT_MAX)  || (eq_full == CNT_MAX));
   end

   // Stage 2 accumulate; cleared when the packet result is handed off.
   always_ff @(posedge clk) begin
      if (RESET || (out_valid && out_ready)) begin
         out_sum    <= '0;
         out_gt_cnt <= '0;
         out_lt_cnt <= '0;
         out_eq_cnt <= '0;
         out_sat    <= 1'b0;
      end else if (s1_vld) begin
         out_sum    <= sum_full[ACC_W-1:0];
         out_gt_cnt <= gt_full[CNT_W-1:0];
         out_lt_cnt <= lt_full[CNT_W-1:0];
         out_eq_cnt <= eq_full[CNT_W-1:0];
         out_sat    <= out_sat || sat_hit;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (RESET) begin
         state <= ACC;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: the last beat leaves stage 2 one cycle after entering DRAIN.
   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (accept && in_last)  state_nxt = DRAIN;
         DRAIN:   if (s1_vld && s1_last)  state_nxt = DONE;
         DONE:    if (out_ready)          state_nxt = ACC;
         default:                         state_nxt = ACC;
      endcase
   end

   // FSM outputs decoded from state only, so out_ready never reaches in_ready.
   always_comb begin
      in_ready  = (state == ACC);
      out_valid = (state == DONE);
   end

endmodule

// File: tb/tb_abs_diff_accum.sv
module tb_abs_diff_accum;

   logic        clk = 1'b0;
   logic        RESET;
   logic        in_valid;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_last;
   logic        out_ready;

   logic        in_ready,  out_valid;
   logic [15:0] out_sum;
   logic [7:0]  out_gt_cnt, out_lt_cnt, out_eq_cnt;
   logic        out_sat;

   logic        rdy12, vld12, sat12;
   logic [11:0] sum12;
   logic [7:0]  gt12, lt12, eq12;
   logic        rdy11, vld11, sat11;
   logic [10:0] sum11;
   logic [7:0]  gt11, lt11, eq11;
   logic        rdy11w, vld11w, sat11w;
   logic [10:0] sum11w;
   logic [7:0]  gt11w, lt11w, eq11w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   abs_diff_accum u_dut (
      .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_gt_cnt(out_gt_cnt),
      .out_lt_cnt(out_lt_cnt), .out_eq_cnt(out_eq_cnt), .out_sat(out_sat));

   abs_diff_accum #(.ACC_W(12), .SATURATE(1)) u_dut12 (
      .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_ready(rdy12),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld12),
      .out_ready(out_ready), .out_sum(sum12), .out_gt_cnt(gt12),
      .out_lt_cnt(lt12), .out_eq_cnt(eq12), .out_sat(sat12));

   abs_diff_accum #(.ACC_W(11), .SATURATE(1)) u_dut11 (
      .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_ready(rdy11),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld11),
      .out_ready(out_ready), .out_sum(sum11), .out_gt_cnt(gt11),
      .out_lt_cnt(lt11), .out_eq_cnt(eq11), .out_sat(sat11));

   abs_diff_accum #(.ACC_W(11), .SATURATE(0)) u_dut11w (
      .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_ready(rdy11w),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld11w),
      .out_ready(out_ready), .out_sum(sum11w), .out_gt_cnt(gt11w),
      .out_lt_cnt(lt11w), .out_eq_cnt(eq11w), .out_sat(sat11w));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          sum;
      int          gt;
      int          lt;
      int          eq;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat and returns just after the edge that accepts it.
   task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
      int n;
      in_a = a;
      in_b = b;
      in_last = last;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic wait_out(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      check({name, "_out_valid"}, 64'(out_valid), 64'd1);
   endtask

   task automatic check_main(input string name, input int sum, input int gt,
                             input int lt, input int eq, input int sat);
      check({name, "_sum"}, 64'(out_sum), 64'(sum));
      check({name, "_gt"},  64'(out_gt_cnt), 64'(gt));
      check({name, "_lt"},  64'(out_lt_cnt), 64'(lt));
      check({name, "_eq"},  64'(out_eq_cnt), 64'(eq));
      check({name, "_sat"}, 64'(out_sat), 64'(sat));
   endtask

   task automatic consume(input string name);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({name, "_rdy_back"}, 64'(in_ready), 64'd1);
      check({name, "_vld_gone"}, 64'(out_valid), 64'd0);
   endtask

   // Reference: sum of |a-b| over the four byte lanes of every beat in a packet.
   function automatic int lane(input logic [31:0] v, input int i);
      return int'((v >> (8 * i)) & 32'hFF);
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  v;
      RESET = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_last = 1'b0;
      out_ready = 1'b0;

      vecs[0] = '{a: {8'd7, 8'd7, 8'd3, 8'd10},       b: {8'd0, 8'd7, 8'd9, 8'd4},
                  sum: 19, gt: 2, lt: 1, eq: 1};
      vecs[1] = '{a: {8'd5, 8'd5, 8'd5, 8'd5},        b: {8'd5, 8'd5, 8'd5, 8'd5},
                  sum: 0, gt: 0, lt: 0, eq: 4};
      vecs[2] = '{a: {8'd0, 8'd255, 8'd0, 8'd255},    b: {8'd255, 8'd0, 8'd255, 8'd0},
                  sum: 1020, gt: 2, lt: 2, eq: 0};
      vecs[3] = '{a: {8'd4, 8'd3, 8'd2, 8'd1},        b: {8'd1, 8'd2, 8'd3, 8'd4},
                  sum: 8, gt: 2, lt: 2, eq: 0};
      vecs[4] = '{a: {8'd0, 8'd0, 8'd0, 8'd0},        b: {8'd1, 8'd50, 8'd100, 8'd200},
                  sum: 351, gt: 0, lt: 4, eq: 0};
      vecs[5] = '{a: {8'd128, 8'd127, 8'd129, 8'd128}, b: {8'd127, 8'd128, 8'd128, 8'd128},
                  sum: 3, gt: 2, lt: 1, eq: 1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      RESET = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check_main("rst", 0, 0, 0, 0, 0);

      // Single-beat packets from the table, with T+2 latency checks
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         send_beat(v.a, v.b, 1'b1);
         check($sformatf("vec%0d_t1_valid", i), 64'(out_valid), 64'd0);
         check($sformatf("vec%0d_t1_ready", i), 64'(in_ready), 64'd0);
         step();
         check($sformatf("vec%0d_t2_valid", i), 64'(out_valid), 64'd1);
         check_main($sformatf("vec%0d", i), v.sum, v.gt, v.lt, v.eq, 0);
         consume($sformatf("vec%0d", i));
      end

      // Three back-to-back beats of 255 vs 0 on all lanes, across accumulator widths
      send_beat(32'hFFFF_FFFF, 32'h0, 1'b0);
      send_beat(32'hFFFF_FFFF, 32'h0, 1'b0);
      send_beat(32'hFFFF_FFFF, 32'h0, 1'b1);
      check("big_t1_valid", 64'(out_valid), 64'd0);
      step();
      check("big_t2_valid", 64'(out_valid), 64'd1);
      check_main("big16", 3060, 12, 0, 0, 0);
      check("big12_sum", 64'(sum12), 64'd3060);
      check("big12_sat", 64'(sat12), 64'd0);
      check("big11_sum", 64'(sum11), 64'd2047);
      check("big11_sat", 64'(sat11), 64'd1);
      check("big11w_sum", 64'(sum11w), 64'd1012);
      check("big11w_sat", 64'(sat11w), 64'd0);
      consume("big");

      // Sum landing exactly on 2047
      send_beat(32'hFFFF_FFFF, 32'h0, 1'b0);
      send_beat(32'hFFFF_FFFF, 32'h0, 1'b0);
      send_beat(32'h0000_0007, 32'h0, 1'b1);
      wait_out("edge");
      check_main("edge16", 2047, 9, 0, 3, 0);
      check("edge11_sum", 64'(sum11), 64'd2047);
      check("edge11_sat", 64'(sat11), 64'd1);
      check("edge11w_sum", 64'(sum11w), 64'd2047);
      check("edge11w_sat", 64'(sat11w), 64'd0);
      check("edge12_sat", 64'(sat12), 64'd0);
      consume("edge");

      // Result held for 5 cycles without out_ready
      send_beat(vecs[2].a, vecs[2].b, 1'b1);
      wait_out("hold");
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("hold%0d_valid", k), 64'(out_valid), 64'd1);
         check($sformatf("hold%0d_ready", k), 64'(in_ready), 64'd0);
         check($sformatf("hold%0d_sum", k), 64'(out_sum), 64'd1020);
         check($sformatf("hold%0d_gt", k), 64'(out_gt_cnt), 64'd2);
      end
      consume("hold");
      send_beat(vecs[1].a, vecs[1].b, 1'b1);
      wait_out("after_hold");
      check_main("after_hold", 0, 0, 0, 4, 0);
      consume("after_hold");

      // Reset in the middle of an unfinished packet
      send_beat(vecs[0].a, vecs[0].b, 1'b0);
      send_beat(vecs[2].a, vecs[2].b, 1'b0);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_ready", 64'(in_ready), 64'd1);
      step();
      check("midrst_sum_clear", 64'(out_sum), 64'd0);
      send_beat(32'h0505_0505, 32'h0505_0505, 1'b1);
      wait_out("postrst");
      check_main("postrst", 0, 0, 0, 4, 0);
      consume("postrst");

      // Random packets against the reference model
      for (int p = 0; p < 40; p++) begin
         int          nb;
         bit          early;
         longint      tot;
         int          gt, lt, eq;
         logic [31:0] a, b;
         nb = $urandom_range(1, 6);
         early = ($urandom_range(0, 3) == 0);
         tot = 0; gt = 0; lt = 0; eq = 0;
         if (early) out_ready = 1'b1;
         for (int k = 0; k < nb; k++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int d = 0; d < idle; d++) step();
            a = $urandom;
            b = $urandom;
            for (int i = 0; i < 4; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  b = (b & ~(32'hFF << (8 * i))) | (a & (32'hFF << (8 * i)));
               end
            end
            for (int i = 0; i < 4; i++) begin
               int x, y;
               x = lane(a, i);
               y = lane(b, i);
               if (x > y)      begin tot += x - y; gt++; end
               else if (x < y) begin tot += y - x; lt++; end
               else            eq++;
            end
            send_beat(a, b, k == nb - 1);
         end
         wait_out($sformatf("rnd%0d", p));
         check_main($sformatf("rnd%0d", p), int'(tot), gt, lt, eq, 0);
         check($sformatf("rnd%0d_sum12", p), 64'(sum12), 64'(tot > 4095 ? 4095 : tot));
         check($sformatf("rnd%0d_sum11", p), 64'(sum11), 64'(tot > 2047 ? 2047 : tot));
         check($sformatf("rnd%0d_sat11", p), 64'(sat11), 64'(tot >= 2047));
         check($sformatf("rnd%0d_sum11w", p), 64'(sum11w), 64'(tot % 2048));
         if (early) begin
            step();
            out_ready = 1'b0;
            check($sformatf("rnd%0d_rdy_back", p), 64'(in_ready), 64'd1);
         end else begin
            int dly;
            dly = $urandom_range(0, 3);
            for (int d = 0; d < dly; d++) step();
            check($sformatf("rnd%0d_still", p), 64'(out_valid), 64'd1);
            consume($sformatf("rnd%0d", p));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
